// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg -- shared constants and state encoding for the MII transmitter.
//
// Contents:
//   PREAMBLE_NIB / SFD_NIB     nibbles sent ahead of the frame body
//   CRC_POLY / CRC_INIT        reflected Ethernet CRC-32 polynomial and seed
//   DEFAULT_IFG_NIBBLES        96 bit times expressed in MII nibbles
//   DEFAULT_MIN_PAYLOAD        minimum bytes ahead of the FCS when padding
//   tx_state_t                 transmitter state encoding
//
// Build option: ETH_TX_PAD_EN adds the PAD state to the encoding.
// ---------------------------------------------------------------------------
package eth_pkg;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;

  localparam int DEFAULT_IFG_NIBBLES = 24;
  localparam int DEFAULT_MIN_PAYLOAD = 60;
  localparam int PREAMBLE_NIBBLES    = 15;
  localparam int FCS_NIBBLES         = 8;

  // S_ABORT is the single error nibble sent when the source runs dry.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_SFD      = 3'd2,
    S_DATA     = 3'd3,
    S_FCS      = 3'd4,
    S_IFG      = 3'd5,
    S_ABORT    = 3'd6
`ifdef ETH_TX_PAD_EN
    ,
    S_PAD      = 3'd7
`endif
  } tx_state_t;

endpackage

// File: rtl/eth_crc32_nibble.sv
// ---------------------------------------------------------------------------
// eth_crc32_nibble -- combinational one-nibble step of the reflected
// Ethernet CRC-32 (LSB of the nibble is processed first).
//
// Ports:
//   crc_in   [31:0] in   running CRC before this nibble
//   nib      [3:0]  in   nibble exactly as it appears on the MII
//   crc_out  [31:0] out  running CRC after this nibble
// ---------------------------------------------------------------------------
module eth_crc32_nibble
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [3:0]  nib,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ nib[i]) c = {1'b0, c[31:1]} ^ CRC_POLY;
      else               c = {1'b0, c[31:1]};
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_mii_tx.sv
// ---------------------------------------------------------------------------
// eth_mii_tx -- byte-stream to MII nibble transmitter. Adds preamble, SFD,
// optional zero padding and the CRC-32 FCS, then enforces the inter-frame
// gap. Every output is a flop loaded from the next-state logic.
//
// Parameters:
//   IFG_NIBBLES  minimum eth_tx_en-low cycles between frames
//   MIN_PAYLOAD  minimum bytes ahead of the FCS (padding builds only)
//
// Ports:
//   eth_tx_clk         in   25 MHz MII transmit clock, only clock
//   rst                in   synchronous, active-high reset
//   s_tdata[7:0]       in   frame byte, destination MAC first
//   s_tvalid           in   s_tdata valid
//   s_tlast            in   final byte of the frame
//   s_tready           out  byte taken when s_tvalid && s_tready
//   eth_txd[3:0]       out  MII transmit nibble
//   eth_tx_en          out  MII transmit enable
//   eth_tx_er          out  MII transmit error (underflow only)
//   frame_done         out  pulse the cycle after the last FCS nibble
//   tx_underflow       out  pulse on the error nibble of an aborted frame
//
// Build option: define ETH_TX_PAD_EN to pad short frames to MIN_PAYLOAD.
//
// The IFG state lasts IFG_NIBBLES-1 cycles and is followed by IDLE, which
// itself transmits nothing; a byte waiting at IDLE therefore starts its
// preamble exactly IFG_NIBBLES quiet cycles after the previous frame.
// ---------------------------------------------------------------------------
module eth_mii_tx
  import eth_pkg::*;
#(
  parameter int IFG_NIBBLES = DEFAULT_IFG_NIBBLES,
  parameter int MIN_PAYLOAD = DEFAULT_MIN_PAYLOAD
) (
  input  logic       eth_tx_clk,
  input  logic       rst,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic [3:0] eth_txd,
  output logic       eth_tx_en,
  output logic       eth_tx_er,
  output logic       frame_done,
  output logic       tx_underflow
);

  localparam int CNT_W = $clog2(IFG_NIBBLES + PREAMBLE_NIBBLES);

`ifdef ETH_TX_PAD_EN
  localparam logic [10:0] PAD_TARGET = 11'(MIN_PAYLOAD);
`else
  // Without padding the minimum payload plays no part.
  logic [10:0] unused_min_payload;
  assign unused_min_payload = 11'(MIN_PAYLOAD);
`endif

  tx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             nib_hi, nib_hi_n;   // 1: high nibble of the byte is on the wire
  logic [7:0]       data_q, data_n;
  logic             last_q, last_n;
  logic [10:0]      byte_cnt, byte_cnt_n, byte_inc;
  logic [31:0]      crc, crc_n, crc_step;
  logic [3:0]       crc_nib;
  logic [3:0]       txd_n;
  logic             en_n, er_n, rdy_n, done_n, uf_n;
  logic             accept;

  eth_crc32_nibble u_crc (
    .crc_in  (crc),
    .nib     (crc_nib),
    .crc_out (crc_step)
  );

  assign accept = s_tvalid && s_tready;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    nib_hi_n   = nib_hi;
    data_n     = data_q;
    last_n     = last_q;
    byte_cnt_n = byte_cnt;
    crc_n      = crc;
    crc_nib    = '0;
    txd_n      = '0;
    en_n       = 1'b0;
    er_n       = 1'b0;
    rdy_n      = 1'b0;
    done_n     = 1'b0;
    uf_n       = 1'b0;

    // Count saturates; long frames keep flowing, only the pad test uses it.
    byte_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;

    unique case (state)
      S_IDLE: begin
        rdy_n = 1'b1;
        if (accept) begin
          data_n     = s_tdata;
          last_n     = s_tlast;
          byte_cnt_n = '0;
          cnt_n      = '0;
          state_n    = S_PREAMBLE;
          rdy_n      = 1'b0;
          en_n       = 1'b1;
          txd_n      = PREAMBLE_NIB;
        end
      end

      S_PREAMBLE: begin
        en_n = 1'b1;
        if (cnt == CNT_W'(PREAMBLE_NIBBLES - 1)) begin
          state_n = S_SFD;
          txd_n   = SFD_NIB;
          crc_n   = CRC_INIT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
          txd_n = PREAMBLE_NIB;
        end
      end

      S_SFD: begin
        en_n     = 1'b1;
        state_n  = S_DATA;
        nib_hi_n = 1'b0;
        txd_n    = data_q[3:0];
        crc_nib  = data_q[3:0];
        crc_n    = crc_step;
      end

      S_DATA: begin
        en_n = 1'b1;
        if (!nib_hi) begin
          // Moving onto the high nibble: the only cycle a new byte may enter.
          nib_hi_n   = 1'b1;
          txd_n      = data_q[7:4];
          crc_nib    = data_q[7:4];
          crc_n      = crc_step;
          byte_cnt_n = byte_inc;
          rdy_n      = !last_q;
        end else if (!last_q) begin
          if (accept) begin
            data_n   = s_tdata;
            last_n   = s_tlast;
            nib_hi_n = 1'b0;
            txd_n    = s_tdata[3:0];
            crc_nib  = s_tdata[3:0];
            crc_n    = crc_step;
          end else begin
            state_n = S_ABORT;
            er_n    = 1'b1;
            uf_n    = 1'b1;
          end
`ifdef ETH_TX_PAD_EN
        end else if (byte_cnt < PAD_TARGET) begin
          state_n  = S_PAD;
          nib_hi_n = 1'b0;
          crc_n    = crc_step;
`endif
        end else begin
          // crc already covers the nibble on the wire; stream it out inverted.
          state_n = S_FCS;
          cnt_n   = '0;
          txd_n   = ~crc[3:0];
          crc_n   = {4'h0, crc[31:4]};
        end
      end

`ifdef ETH_TX_PAD_EN
      S_PAD: begin
        en_n = 1'b1;
        if (!nib_hi) begin
          nib_hi_n   = 1'b1;
          crc_n      = crc_step;
          byte_cnt_n = byte_inc;
        end else if (byte_cnt < PAD_TARGET) begin
          nib_hi_n = 1'b0;
          crc_n    = crc_step;
        end else begin
          state_n = S_FCS;
          cnt_n   = '0;
          txd_n   = ~crc[3:0];
          crc_n   = {4'h0, crc[31:4]};
        end
      end
`endif

      S_FCS: begin
        if (cnt == CNT_W'(FCS_NIBBLES - 1)) begin
          state_n = S_IFG;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          en_n  = 1'b1;
          cnt_n = cnt + CNT_W'(1);
          txd_n = ~crc[3:0];
          crc_n = {4'h0, crc[31:4]};
        end
      end

      S_ABORT: begin
        state_n = S_IFG;
        cnt_n   = '0;
      end

      S_IFG: begin
        if (cnt == CNT_W'(IFG_NIBBLES - 2)) begin
          state_n = S_IDLE;
          rdy_n   = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the values from before this edge.
  always_ff @(posedge eth_tx_clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      nib_hi       <= 1'b0;
      data_q       <= '0;
      last_q       <= 1'b0;
      byte_cnt     <= '0;
      crc          <= CRC_INIT;
      s_tready     <= 1'b0;
      eth_txd      <= '0;
      eth_tx_en    <= 1'b0;
      eth_tx_er    <= 1'b0;
      frame_done   <= 1'b0;
      tx_underflow <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      nib_hi       <= nib_hi_n;
      data_q       <= data_n;
      last_q       <= last_n;
      byte_cnt     <= byte_cnt_n;
      crc          <= crc_n;
      s_tready     <= rdy_n;
      eth_txd      <= txd_n;
      eth_tx_en    <= en_n;
      eth_tx_er    <= er_n;
      frame_done   <= done_n;
      tx_underflow <= uf_n;
    end
  end

endmodule

// File: tb/tb_eth_mii_tx.sv
// ---------------------------------------------------------------------------
// tb_eth_mii_tx -- self-checking bench for eth_mii_tx. Each cycle is sampled
// on the falling edge into a log; frames are compared against a byte-level
// model (preamble, optional padding, bitwise CRC-32). Honours ETH_TX_PAD_EN.
// ---------------------------------------------------------------------------
module tb_eth_mii_tx;

  localparam int IFG  = 24;
  localparam int MINP = 60;

  logic       eth_tx_clk = 1'b0;
  logic       rst        = 1'b1;
  logic [7:0] s_tdata    = '0;
  logic       s_tvalid   = 1'b0;
  logic       s_tlast    = 1'b0;
  logic       s_tready;
  logic [3:0] eth_txd;
  logic       eth_tx_en, eth_tx_er, frame_done, tx_underflow;

  eth_mii_tx #(.IFG_NIBBLES(IFG), .MIN_PAYLOAD(MINP)) dut (
    .eth_tx_clk   (eth_tx_clk),
    .rst          (rst),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tlast      (s_tlast),
    .s_tready     (s_tready),
    .eth_txd      (eth_txd),
    .eth_tx_en    (eth_tx_en),
    .eth_tx_er    (eth_tx_er),
    .frame_done   (frame_done),
    .tx_underflow (tx_underflow)
  );

  always #20 eth_tx_clk = ~eth_tx_clk;

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       en;
    logic       er;
    logic [3:0] txd;
    logic       rdy;
    logic       done;
    logic       uf;
    logic       acc;
  } smp_t;
  typedef logic [7:0] byte_q_t [$];
  typedef logic [3:0] nib_q_t [$];

  // "123456789" with padding off: preamble, SFD, data, FCS of 0xCBF43926.
  localparam logic [3:0] LIT [0:41] = '{
    4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5,
    4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'hD,
    4'h1, 4'h3, 4'h2, 4'h3, 4'h3, 4'h3, 4'h4, 4'h3, 4'h5, 4'h3,
    4'h6, 4'h3, 4'h7, 4'h3, 4'h8, 4'h3, 4'h9, 4'h3,
    4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC
  };

  smp_t       log_q [$];
  logic [8:0] src_q [$];
  int         en_run, bursts_done;
  logic       en_prev;
  int         n_cmp, n_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs, then present the head of the source queue.
  task automatic step();
    smp_t s;
    @(negedge eth_tx_clk);
    s.en   = eth_tx_en;
    s.er   = eth_tx_er;
    s.txd  = eth_txd;
    s.rdy  = s_tready;
    s.done = frame_done;
    s.uf   = tx_underflow;
    if (src_q.size() > 0) begin
      s_tvalid = 1'b1;
      s_tdata  = src_q[0][7:0];
      s_tlast  = src_q[0][8];
      if (s_tready) void'(src_q.pop_front());
    end else begin
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = 8'($urandom);
    end
    s.acc = s_tvalid && s_tready;
    log_q.push_back(s);
    en_run = eth_tx_en ? en_run + 1 : 0;
    if (en_prev && !eth_tx_en) bursts_done++;
    en_prev = eth_tx_en;
  endtask

  task automatic push_frame(input byte_q_t b, input bit mark_last);
    foreach (b[i]) src_q.push_back({mark_last && (i == b.size() - 1), b[i]});
  endtask

  task automatic rand_bytes(input int n, output byte_q_t b);
    b = {};
    repeat (n) b.push_back(8'($urandom));
  endtask

  task automatic run_bursts(input string tag, input int n, input int budget);
    int c = 0;
    while (bursts_done < n && c < budget) begin
      step();
      c++;
    end
    check({tag, " bursts completed"}, bursts_done, n);
    repeat (4) step();
  endtask

  // Reference: what should appear on eth_txd while eth_tx_en is high.
  task automatic model_frame(input byte_q_t bytes, output nib_q_t nibs);
    byte_q_t     p;
    logic [31:0] c;
    p    = bytes;
    nibs = {};
    repeat (15) nibs.push_back(4'h5);
    nibs.push_back(4'hD);
`ifdef ETH_TX_PAD_EN
    while (p.size() < MINP) p.push_back(8'h00);
`endif
    c = 32'hFFFF_FFFF;
    foreach (p[i]) begin
      c = c ^ {24'h0, p[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      nibs.push_back(p[i][3:0]);
      nibs.push_back(p[i][7:4]);
    end
    c = ~c;
    for (int k = 0; k < 8; k++) nibs.push_back(c[4*k +: 4]);
  endtask

  function automatic int burst_start(input int b);
    int seen = 0;
    foreach (log_q[i]) begin
      if (log_q[i].en && (i == 0 || !log_q[i-1].en)) begin
        if (seen == b) return i;
        seen++;
      end
    end
    return -1;
  endfunction

  function automatic int burst_len(input int s);
    int n = 0;
    while (s + n < log_q.size() && log_q[s+n].en) n++;
    return n;
  endfunction

  task automatic check_frame(input string tag, input int b, input byte_q_t bytes);
    nib_q_t exp;
    int s, n, mism, ers;
    model_frame(bytes, exp);
    s = burst_start(b);
    check({tag, " burst present"}, (s >= 1), 1);
    if (s < 1) return;
    n = burst_len(s);
    check({tag, " tx_en length"}, n, exp.size());
    mism = 0;
    ers  = 0;
    for (int k = 0; k < n && k < exp.size(); k++) begin
      if (log_q[s+k].txd !== exp[k]) mism++;
      if (log_q[s+k].er) ers++;
    end
    check({tag, " nibble mismatches"}, mism, 0);
    check({tag, " tx_er cycles"}, ers, 0);
    check({tag, " accepted cycle before preamble"}, log_q[s-1].acc, 1);
    if (s + n < log_q.size()) check({tag, " frame_done after FCS"}, log_q[s+n].done, 1);
  endtask

  function automatic int count_done();
    int n = 0;
    foreach (log_q[i]) if (log_q[i].done) n++;
    return n;
  endfunction

  function automatic int count_uf();
    int n = 0;
    foreach (log_q[i]) if (log_q[i].uf) n++;
    return n;
  endfunction

  function automatic int count_idle_txd();
    int n = 0;
    foreach (log_q[i]) if (!log_q[i].en && log_q[i].txd != 4'h0) n++;
    return n;
  endfunction

  initial begin
    byte_q_t b, b2;
    nib_q_t  exp;
    smp_t    last;
    int      s, n, s2, c, tgt, cnt, mism;
    bit      seen;

    n_cmp = 0; n_bad = 0; en_run = 0; bursts_done = 0; en_prev = 1'b0;

    // ---- reset values ----
    rst = 1'b1;
    repeat (3) step();
    last = log_q[log_q.size()-1];
    check("reset s_tready", last.rdy, 0);
    check("reset tx_en", last.en, 0);
    check("reset tx_er", last.er, 0);
    check("reset txd", last.txd, 0);
    check("reset frame_done", last.done, 0);
    check("reset tx_underflow", last.uf, 0);
    rst = 1'b0;
    step();
    check("post-reset s_tready", log_q[log_q.size()-1].rdy, 1);
    log_q.delete();

    // ---- directed frame ----
    bursts_done = 0;
`ifdef ETH_TX_PAD_EN
    b = '{8'hAB};
`else
    b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
`endif
    push_frame(b, 1'b1);
    run_bursts("dir", 1, 600);
    check_frame("dir", 0, b);
    s = burst_start(0);
    n = (s >= 0) ? burst_len(s) : 0;
`ifdef ETH_TX_PAD_EN
    check("dir pad length", n, 144);
    if (n == 144) begin
      check("dir nibble B", log_q[s+16].txd, 4'hB);
      check("dir nibble A", log_q[s+17].txd, 4'hA);
      cnt = 0;
      for (int k = 18; k < 136; k++) if (log_q[s+k].txd == 4'h0) cnt++;
      check("dir zero pad nibbles", cnt, 118);
    end
`else
    check("dir length", n, 42);
    if (n == 42) begin
      mism = 0;
      for (int k = 0; k < 42; k++) if (log_q[s+k].txd !== LIT[k]) mism++;
      check("dir known-answer nibbles", mism, 0);
    end
`endif
    check("dir frame_done pulses", count_done(), 1);
    check("dir underflow pulses", count_uf(), 0);
    check("dir txd zero while idle", count_idle_txd(), 0);
    log_q.delete();

    // ---- random frames ----
    for (int f = 0; f < 4; f++) begin
      bursts_done = 0;
      rand_bytes($urandom_range(1, 90), b);
      push_frame(b, 1'b1);
      run_bursts($sformatf("rnd%0d", f), 1, 800);
      check_frame($sformatf("rnd%0d", f), 0, b);
      check($sformatf("rnd%0d done pulses", f), count_done(), 1);
      check($sformatf("rnd%0d idle txd", f), count_idle_txd(), 0);
      log_q.delete();
    end

    // ---- back-to-back 64-byte frames ----
    bursts_done = 0;
    rand_bytes(64, b);
    rand_bytes(64, b2);
    push_frame(b, 1'b1);
    push_frame(b2, 1'b1);
    run_bursts("b2b", 2, 1200);
    check_frame("b2b first", 0, b);
    check_frame("b2b second", 1, b2);
    s  = burst_start(0);
    s2 = burst_start(1);
    if (s >= 0 && s2 >= 0) begin
      n = burst_len(s);
      check("b2b gap", s2 - (s + n), IFG);
      cnt = 0;
      for (int k = s + n; k < s + n + IFG - 1; k++) if (log_q[k].rdy) cnt++;
      check("b2b s_tready high in IFG", cnt, 0);
    end
    check("b2b frame_done pulses", count_done(), 2);
    log_q.delete();

    // ---- underflow after byte 5 of 20 ----
    repeat (30) step();
    log_q.delete();
    bursts_done = 0;
    rand_bytes(5, b);
    push_frame(b, 1'b0);
    seen = 1'b0;
    c = 0;
    while (!seen && c < 400) begin
      step();
      c++;
      if (log_q[log_q.size()-1].uf) seen = 1'b1;
    end
    check("ufl pulse seen", seen, 1);
    rand_bytes(10, b2);
    push_frame(b2, 1'b1);
    run_bursts("ufl", 2, 800);
    s = burst_start(0);
    if (s >= 0) begin
      n = burst_len(s);
      check("ufl aborted burst length", n, 27);
      if (n == 27) begin
        check("ufl error nibble tx_er", log_q[s+26].er, 1);
        check("ufl error nibble txd", log_q[s+26].txd, 0);
        check("ufl underflow on error nibble", log_q[s+26].uf, 1);
        model_frame(b, exp);
        mism = 0;
        for (int k = 0; k < 26; k++) if (log_q[s+k].txd !== exp[k]) mism++;
        check("ufl prefix nibbles", mism, 0);
      end
      s2 = burst_start(1);
      if (s2 >= 0) begin
        check("ufl gap", s2 - (s + n), IFG);
        cnt = 0;
        for (int k = 0; k < s2; k++) if (log_q[k].done) cnt++;
        check("ufl no frame_done", cnt, 0);
      end
    end
    check("ufl underflow pulses", count_uf(), 1);
    check_frame("ufl next", 1, b2);
    log_q.delete();

    // ---- reset during FCS nibble 3 ----
    repeat (30) step();
    log_q.delete();
    bursts_done = 0;
    rand_bytes($urandom_range(8, 40), b);
    model_frame(b, exp);
    tgt = exp.size() - 8 + 4;
    push_frame(b, 1'b1);
    c = 0;
    while (en_run != tgt && c < 800) begin
      step();
      c++;
    end
    check("rst reached FCS nibble 3", en_run, tgt);
    rst = 1'b1;
    step();
    last = log_q[log_q.size()-1];
    check("rst tx_en dropped", last.en, 0);
    check("rst tx_er", last.er, 0);
    check("rst txd", last.txd, 0);
    check("rst s_tready", last.rdy, 0);
    rst = 1'b0;
    step();
    check("rst ready without IFG", log_q[log_q.size()-1].rdy, 1);
    repeat (40) step();
    check("rst frame_done pulses", count_done(), 0);
    check("rst underflow pulses", count_uf(), 0);
    log_q.delete();
    bursts_done = 0;
    rand_bytes($urandom_range(1, 30), b);
    push_frame(b, 1'b1);
    run_bursts("rst next", 1, 800);
    check_frame("rst next", 0, b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
